// File: rtl/lut3_shift_register_if.sv
// lut3_shift_register_if -- signal bundle for the lut3_shift_register cell.
//
// Signals:
//   enable    shift enable (driven by master)
//   S         serial configuration bit (driven by master)
//   A, B, C   LUT select, A is the MSB (driven by master)
//   Z         LUT output (driven by slave)
//   Q_out     configuration readback, 2**SEL_W bits (only with LUT3_QOUT_EN)
//   load_done high once 2**SEL_W shifts have occurred since reset
//             (only with LUT3_QOUT_EN)
//
// Optional feature macro: LUT3_QOUT_EN.
interface lut3_shift_register_if #(
  parameter int SEL_W = 3
);
  logic enable;
  logic S;
  logic A;
  logic B;
  logic C;
  logic Z;
`ifdef LUT3_QOUT_EN
  logic [2**SEL_W-1:0] Q_out;
  logic                load_done;
`endif

`ifdef LUT3_QOUT_EN
  modport master (output enable, S, A, B, C, input Z, Q_out, load_done);
  modport slave  (input enable, S, A, B, C, output Z, Q_out, load_done);
`else
  modport master (output enable, S, A, B, C, input Z);
  modport slave  (input enable, S, A, B, C, output Z);
`endif
endinterface

// File: rtl/lut3_shift_register.sv
// lut3_shift_register -- serial-load shift register used as a programmable
// 3-input lookup table.
//
// Configuration bits enter on bus.S at each rising clock edge with
// bus.enable high (newest bit in Q[0], oldest shifted toward Q[7]). The
// output bus.Z is a purely combinational read of Q[{A,B,C}].
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; loads RESET_VAL, has priority over shift
//   bus    lut3_shift_register_if.slave (enable, S, A, B, C, Z and, with
//          LUT3_QOUT_EN, Q_out / load_done)
//
// Optional feature macro: LUT3_QOUT_EN -- adds Q_out readback and a
// saturating shift counter driving load_done.
module lut3_shift_register #(
  parameter int                SEL_W     = 3,
  parameter logic [2**SEL_W-1:0] RESET_VAL = '0
) (
  input logic                   clk,
  input logic                   reset,
  lut3_shift_register_if.slave  bus
);

  localparam int DEPTH = 2**SEL_W;

  logic [DEPTH-1:0] q;
  logic [2:0]       sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (bus.enable) begin
      q <= {q[DEPTH-2:0], bus.S};
    end
  end

  // Select is zero-latency: no register between {A,B,C} and Z.
  assign sel   = {bus.A, bus.B, bus.C};
  assign bus.Z = q[sel];

`ifdef LUT3_QOUT_EN
  localparam logic [SEL_W:0] CNT_MAX = (SEL_W+1)'(DEPTH);

  // Counts enabled shifts since reset; stops at DEPTH so load_done
  // never drops again until the next reset.
  logic [SEL_W:0] shift_cnt;
  logic           load_done_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_cnt   <= '0;
      load_done_r <= 1'b0;
    end else if (bus.enable && (shift_cnt != CNT_MAX)) begin
      shift_cnt <= shift_cnt + 1'b1;
      if (shift_cnt == CNT_MAX - 1'b1) begin
        load_done_r <= 1'b1;
      end
    end
  end

  assign bus.Q_out     = q;
  assign bus.load_done = load_done_r;
`endif

endmodule

// File: tb/tb_lut3_shift_register.sv
// tb_lut3_shift_register -- self-checking bench for lut3_shift_register.
// Table-driven directed vectors, hand-written multi-cycle sequences and a
// randomized run against a queue-based model of the configuration bits.
`timescale 1ns/1ps
module tb_lut3_shift_register;

  logic clk = 1'b0;
  logic reset;

  lut3_shift_register_if #(.SEL_W(3)) bus ();

  lut3_shift_register #(.SEL_W(3), .RESET_VAL(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #20 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit       clocked;  // 1: apply reset/enable/S across one clock edge first
    bit       rst;
    bit       en;
    bit       s;
    bit [2:0] abc;
    bit       exp_z;
  } vec_t;

  vec_t vecs[$];

  // Reference model: mq[i] is Q[i]; a shift pushes the new bit at index 0
  // and the oldest bit falls off the far end.
  bit mq[$];
  int m_shifts;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 8; i++) mq.push_back(1'b0);
    m_shifts = 0;
  endtask

  task automatic model_shift(input bit s);
    mq.push_front(s);
    void'(mq.pop_back());
    if (m_shifts < 8) m_shifts++;
  endtask

  task automatic set_abc(input bit [2:0] abc);
    {bus.A, bus.B, bus.C} = abc;
  endtask

  // Drive controls at the falling edge, then return 1 ns after the rising edge.
  task automatic step(input logic r, input logic en, input logic s);
    @(negedge clk);
    reset      = r;
    bus.enable = en;
    bus.S      = s;
    @(posedge clk);
    #1;
  endtask

  // Walk all eight addresses; only addresses whose bit is set in exp read 1.
  task automatic check_all(input string name, input logic [7:0] exp);
    for (int i = 0; i < 8; i++) begin
      set_abc(3'(i));
      #1;
      chk(name, {7'b0, bus.Z}, {7'b0, exp[i]});
    end
  endtask

  task automatic add(input bit c, input bit r, input bit en, input bit s,
                     input bit [2:0] abc, input bit z);
    vec_t v;
    v.clocked = c; v.rst = r; v.en = en; v.s = s; v.abc = abc; v.exp_z = z;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] mv;
    bit [2:0]   rabc;
    bit         rs;
    bit         ren;

    reset      = 1'b1;
    bus.enable = 1'b1;
    bus.S      = 1'b1;
    set_abc(3'd0);

    // Reset for two cycles with enable=1, S=1: all addresses read 0.
    add(1, 1, 1, 1, 3'd0, 0);
    add(1, 1, 1, 1, 3'd7, 0);
    for (int i = 1; i < 7; i++) add(0, 0, 0, 0, 3'(i), 0);
    // AND-gate load: the lone 1 walks from Q[0] to Q[7].
    for (int i = 0; i < 8; i++) add(1, 0, 1, (i == 0), 3'(i), 1);
    add(1, 0, 0, 0, 3'd7, 1);
    add(0, 0, 0, 0, 3'd5, 0);
    add(0, 0, 0, 0, 3'd6, 0);
    add(0, 0, 0, 0, 3'd7, 1);
    add(0, 0, 0, 0, 3'd0, 0);
    add(0, 0, 0, 0, 3'd1, 0);

    foreach (vecs[k]) begin
      if (vecs[k].clocked) step(vecs[k].rst, vecs[k].en, vecs[k].s);
      set_abc(vecs[k].abc);
      #1;
      chk($sformatf("vec%0d_abc%0d", k, vecs[k].abc), {7'b0, bus.Z}, {7'b0, vecs[k].exp_z});
    end

    // Hold with S unknown: contents stay 8'h80.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'bx);
    check_all("hold_x", 8'h80);
`ifdef LUT3_QOUT_EN
    chk("hold_qout", bus.Q_out, 8'h80);
    chk("hold_load_done", {7'b0, bus.load_done}, 8'h01);
`endif

    // Single shift from zero; Z at ABC=0 shows old Q before the edge and
    // the new bit right after it.
    step(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset      = 1'b0;
    bus.enable = 1'b1;
    bus.S      = 1'b1;
    set_abc(3'd0);
    #1;
    chk("single_pre_edge", {7'b0, bus.Z}, 8'h00);
    @(posedge clk);
    #1;
    chk("single_post_edge", {7'b0, bus.Z}, 8'h01);
    step(1'b0, 1'b0, 1'b0);
    check_all("single_all", 8'h01);

    // Reset priority over a simultaneous shift.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1);
    check_all("load_ff", 8'hFF);
    step(1'b1, 1'b1, 1'b1);
    set_abc(3'd7);
    #1;
    chk("rst_prio_abc7", {7'b0, bus.Z}, 8'h00);
    check_all("rst_prio_all", 8'h00);
`ifdef LUT3_QOUT_EN
    chk("rst_load_done", {7'b0, bus.load_done}, 8'h00);
`endif

    // Randomized run: 500 cycles, checked after each negedge and posedge.
    model_reset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      reset      = 1'b0;
      ren        = ($urandom_range(3) == 0);
      rs         = 1'($urandom);
      rabc       = 3'($urandom);
      bus.enable = ren;
      bus.S      = rs;
      set_abc(rabc);
      #1;
      chk($sformatf("rand_neg%0d", cyc), {7'b0, bus.Z}, {7'b0, mq[rabc]});
      @(posedge clk);
      if (ren) model_shift(rs);
      #1;
      chk($sformatf("rand_pos%0d", cyc), {7'b0, bus.Z}, {7'b0, mq[rabc]});
`ifdef LUT3_QOUT_EN
      for (int i = 0; i < 8; i++) mv[i] = mq[i];
      chk("rand_qout", bus.Q_out, mv);
      chk("rand_load_done", {7'b0, bus.load_done}, {7'b0, (m_shifts >= 8)});
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
